// File: rtl/scpu_sram_arb.sv
// scpu_sram_arb: two-port (loader / CPU) arbiter in front of a single-port SRAM.
// Round-robin between the ports in run mode and loader-only access in load mode.
// CPU writes below PROT_LIM are granted but never reach the SRAM.
// Each access is IDLE -> ACC (-> RDCAP for reads) -> IDLE.
module scpu_sram_arb #(
    parameter int unsigned                  MEMORY_ADDR_WIDTH = 9,
    parameter int unsigned                  MEMORY_DATA_WIDTH = 8,
    parameter logic [MEMORY_ADDR_WIDTH-1:0] PROT_LIM          = 9'h100
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         LOAD_N,
    // loader port
    input  logic                         LD_REQ,
    input  logic                         LD_WE,
    input  logic [MEMORY_ADDR_WIDTH-1:0] LD_A,
    input  logic [MEMORY_DATA_WIDTH-1:0] LD_D,
    output logic                         LD_GNT,
    output logic                         LD_RVLD,
    output logic [MEMORY_DATA_WIDTH-1:0] LD_Q,
    // CPU port
    input  logic                         CPU_REQ,
    input  logic                         CPU_WE,
    input  logic [MEMORY_ADDR_WIDTH-1:0] CPU_A,
    input  logic [MEMORY_DATA_WIDTH-1:0] CPU_D,
    output logic                         CPU_GNT,
    output logic                         CPU_RVLD,
    output logic                         CPU_ERR,
    output logic [MEMORY_DATA_WIDTH-1:0] CPU_Q,
    // SRAM side
    output logic                         CEN,
    output logic                         WEN,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic [MEMORY_DATA_WIDTH-1:0] D,
    input  logic [MEMORY_DATA_WIDTH-1:0] Q,
    output logic                         BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        RDCAP
    } state_t;

    typedef enum logic {
        PORT_LD,
        PORT_CPU
    } port_t;

    state_t                         state;
    port_t                          favour;    // port preferred when both are eligible
    port_t                          cur_port;  // owner of the access in flight
    logic                           cur_rd;    // access in flight is a read

    logic                           ld_elig;
    logic                           cpu_elig;
    logic                           any_req;
    port_t                          win;
    logic                           win_we;
    logic [MEMORY_ADDR_WIDTH-1:0]   win_a;
    logic [MEMORY_DATA_WIDTH-1:0]   win_d;
    logic                           prot_hit;

    // Eligibility, round-robin winner selection and the winner's request fields.
    always_comb begin
        ld_elig  = LD_REQ;
        cpu_elig = CPU_REQ & LOAD_N;
        any_req  = ld_elig | cpu_elig;

        if (ld_elig && cpu_elig) begin
            win = favour;
        end else if (cpu_elig) begin
            win = PORT_CPU;
        end else begin
            win = PORT_LD;
        end

        if (win == PORT_CPU) begin
            win_we = CPU_WE;
            win_a  = CPU_A;
            win_d  = CPU_D;
        end else begin
            win_we = LD_WE;
            win_a  = LD_A;
            win_d  = LD_D;
        end

        prot_hit = (win == PORT_CPU) && win_we && (win_a < PROT_LIM);
    end

    // Access FSM with all outputs registered; strobes default low and CEN/WEN
    // default high so every edge leaving ACC closes the SRAM cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            favour   <= PORT_LD;
            cur_port <= PORT_LD;
            cur_rd   <= 1'b0;
            CEN      <= 1'b1;
            WEN      <= 1'b1;
            A        <= '0;
            D        <= '0;
            LD_GNT   <= 1'b0;
            LD_RVLD  <= 1'b0;
            LD_Q     <= '0;
            CPU_GNT  <= 1'b0;
            CPU_RVLD <= 1'b0;
            CPU_ERR  <= 1'b0;
            CPU_Q    <= '0;
            BUSY     <= 1'b0;
        end else begin
            CEN      <= 1'b1;
            WEN      <= 1'b1;
            LD_GNT   <= 1'b0;
            CPU_GNT  <= 1'b0;
            CPU_ERR  <= 1'b0;
            LD_RVLD  <= 1'b0;
            CPU_RVLD <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= ACC;
                        BUSY     <= 1'b1;
                        cur_port <= win;
                        cur_rd   <= ~win_we;
                        A        <= win_a;
                        D        <= win_d;
                        favour   <= (win == PORT_LD) ? PORT_CPU : PORT_LD;
                        if (win == PORT_CPU) begin
                            CPU_GNT <= 1'b1;
                        end else begin
                            LD_GNT  <= 1'b1;
                        end
                        // A protected CPU write is granted but the SRAM stays deselected.
                        if (prot_hit) begin
                            CPU_ERR <= 1'b1;
                        end else begin
                            CEN <= 1'b0;
                            WEN <= ~win_we;
                        end
                    end
                end

                ACC: begin
                    if (cur_rd) begin
                        state <= RDCAP;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end

                RDCAP: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    if (cur_port == PORT_CPU) begin
                        CPU_Q    <= Q;
                        CPU_RVLD <= 1'b1;
                    end else begin
                        LD_Q     <= Q;
                        LD_RVLD  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scpu_sram_arb.sv
// tb_scpu_sram_arb: drivers push expected transactions into per-port queues; a
// monitor checks each grant and read return against a transaction-level model
// (round-robin favourite bit plus a memory image).
module tb_scpu_sram_arb;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       LOAD_N = 1'b0;
    logic       LD_REQ = 1'b0, LD_WE = 1'b0;
    logic [8:0] LD_A = '0;
    logic [7:0] LD_D = '0;
    logic       LD_GNT, LD_RVLD;
    logic [7:0] LD_Q;
    logic       CPU_REQ = 1'b0, CPU_WE = 1'b0;
    logic [8:0] CPU_A = '0;
    logic [7:0] CPU_D = '0;
    logic       CPU_GNT, CPU_RVLD, CPU_ERR;
    logic [7:0] CPU_Q;
    logic       CEN, WEN;
    logic [8:0] A;
    logic [7:0] D;
    logic [7:0] Q;
    logic       BUSY;

    scpu_sram_arb #(
        .MEMORY_ADDR_WIDTH(9),
        .MEMORY_DATA_WIDTH(8),
        .PROT_LIM(9'h100)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .LOAD_N(LOAD_N),
        .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_A(LD_A), .LD_D(LD_D),
        .LD_GNT(LD_GNT), .LD_RVLD(LD_RVLD), .LD_Q(LD_Q),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_A(CPU_A), .CPU_D(CPU_D),
        .CPU_GNT(CPU_GNT), .CPU_RVLD(CPU_RVLD), .CPU_ERR(CPU_ERR), .CPU_Q(CPU_Q),
        .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural SRAM: write or read on the edge where CEN is low.
    logic [7:0] sram [512];
    logic [7:0] sram_q = '0;
    always @(posedge CLK) begin
        if (!CEN) begin
            if (!WEN) sram[A] <= D;
            else      sram_q  <= sram[A];
        end
    end
    assign Q = sram_q;

    typedef struct {
        bit         we;
        logic [8:0] a;
        logic [7:0] d;
    } req_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_t;

    req_t       exp_ld[$];
    req_t       exp_cpu[$];
    rd_t        rd_ld[$];
    rd_t        rd_cpu[$];
    logic [7:0] model_mem [512];
    bit         fav_cpu = 1'b0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    bit         snap_ld, snap_cpu;
    bit         rand_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram[i]      = 8'($urandom);
            model_mem[i] = sram[i];
        end
    end

    // Request lines as seen by the DUT on the coming rising edge.
    always @(negedge CLK) begin
        snap_ld  = LD_REQ;
        snap_cpu = CPU_REQ & LOAD_N;
    end

    // Monitor: checks every grant and read-valid against the scoreboard.
    always begin
        req_t t;
        rd_t  r;
        bit   prot;
        bit   exp_rv;
        int   exp_win;
        @(posedge CLK);
        #1;
        cyc++;
        if (!RST_N) begin
            rd_ld.delete();
            rd_cpu.delete();
            fav_cpu = 1'b0;
            check("rst_rvld", {LD_RVLD, CPU_RVLD}, 0);
        end else begin
            if (LD_GNT || CPU_GNT) begin
                check("gnt_excl", LD_GNT & CPU_GNT, 0);
                if (snap_ld && snap_cpu) exp_win = fav_cpu ? 1 : 0;
                else if (snap_cpu)       exp_win = 1;
                else if (snap_ld)        exp_win = 0;
                else                     exp_win = 2;
                check("arb_winner", CPU_GNT, exp_win);
                fav_cpu = !CPU_GNT;
                check("gnt_pending", CPU_GNT ? exp_cpu.size() : exp_ld.size(), 1);
                if ((CPU_GNT ? exp_cpu.size() : exp_ld.size()) > 0) begin
                    t = CPU_GNT ? exp_cpu.pop_front() : exp_ld.pop_front();
                    prot = CPU_GNT && t.we && (t.a < 9'h100);
                    check("acc_a", A, t.a);
                    check("acc_d", D, t.d);
                    check("acc_err", CPU_ERR, prot);
                    check("acc_cen", CEN, prot);
                    check("acc_wen", WEN, prot ? 1'b1 : !t.we);
                    check("acc_busy", BUSY, 1);
                    if (t.we && !prot) model_mem[t.a] = t.d;
                    if (!t.we) begin
                        r.data = model_mem[t.a];
                        r.due  = cyc + 2;
                        if (CPU_GNT) rd_cpu.push_back(r);
                        else         rd_ld.push_back(r);
                    end
                end
            end else begin
                check("cen_idle", {CEN, CPU_ERR}, 2'b10);
            end

            exp_rv = (rd_ld.size() > 0) && (rd_ld[0].due == cyc);
            if (exp_rv || LD_RVLD) begin
                check("ld_rvld", LD_RVLD, exp_rv);
                if (exp_rv && LD_RVLD) check("ld_q", LD_Q, rd_ld[0].data);
                if (exp_rv) void'(rd_ld.pop_front());
            end
            exp_rv = (rd_cpu.size() > 0) && (rd_cpu[0].due == cyc);
            if (exp_rv || CPU_RVLD) begin
                check("cpu_rvld", CPU_RVLD, exp_rv);
                if (exp_rv && CPU_RVLD) check("cpu_q", CPU_Q, rd_cpu[0].data);
                if (exp_rv) void'(rd_cpu.pop_front());
            end
            if ((rd_ld.size() > 0 && rd_ld[0].due == cyc + 1) ||
                (rd_cpu.size() > 0 && rd_cpu[0].due == cyc + 1))
                check("busy_rdcap", BUSY, 1);
        end
    end

    // One requester transaction with the hold-until-grant handshake.
    task automatic do_req(input bit cpu, input bit we, input logic [8:0] a, input logic [7:0] d);
        req_t t;
        bit   got;
        t.we = we; t.a = a; t.d = d;
        if (cpu) exp_cpu.push_back(t);
        else     exp_ld.push_back(t);
        @(posedge CLK);
        #1;
        if (cpu) begin CPU_WE = we; CPU_A = a; CPU_D = d; CPU_REQ = 1'b1; end
        else     begin LD_WE  = we; LD_A  = a; LD_D  = d; LD_REQ  = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge CLK);
            #1;
            got = cpu ? CPU_GNT : LD_GNT;
        end
        check(cpu ? "cpu_gnt_wait" : "ld_gnt_wait", got, 1);
        if (got) begin
            @(posedge CLK);
            #1;
        end
        if (cpu) CPU_REQ = 1'b0;
        else     LD_REQ  = 1'b0;
    endtask

    function automatic logic [8:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 9'h0FF;
            1:       return 9'h100;
            default: return 9'($urandom_range(0, 511));
        endcase
    endfunction

    task automatic rand_port(input bit cpu, input int n);
        for (int i = 0; i < n; i++) begin
            do_req(cpu, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge CLK);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        // reset values
        #23;
        check("rst_cen", CEN, 1);
        check("rst_wen", WEN, 1);
        check("rst_a", A, 0);
        check("rst_d", D, 0);
        check("rst_strobes", {LD_GNT, CPU_GNT, LD_RVLD, CPU_RVLD, CPU_ERR}, 0);
        check("rst_ld_q", LD_Q, 0);
        check("rst_cpu_q", CPU_Q, 0);
        check("rst_busy", BUSY, 0);
        @(posedge CLK);
        #3 RST_N = 1'b1;

        // load mode: loader write while the CPU holds a request that must be ignored
        LOAD_N = 1'b0;
        @(posedge CLK);
        #1;
        CPU_WE = 1'b1; CPU_A = 9'h150; CPU_D = 8'h77; CPU_REQ = 1'b1;
        do_req(1'b0, 1'b1, 9'h005, 8'hA5);
        repeat (3) @(posedge CLK);
        #1 CPU_REQ = 1'b0;

        // preload then run-mode CPU read latency
        do_req(1'b0, 1'b1, 9'h105, 8'h3C);
        LOAD_N = 1'b1;
        do_req(1'b1, 1'b0, 9'h105, 8'h00);
        repeat (4) @(posedge CLK);

        // write protection boundary with loader readback
        do_req(1'b1, 1'b1, 9'h0FF, 8'h11);
        do_req(1'b0, 1'b0, 9'h0FF, 8'h00);
        do_req(1'b1, 1'b1, 9'h100, 8'h22);
        do_req(1'b0, 1'b0, 9'h100, 8'h00);
        repeat (4) @(posedge CLK);

        // reset during RDCAP: access aborts, then both pending ports re-arbitrate
        do_req(1'b1, 1'b0, 9'h105, 8'h00);
        #2 RST_N = 1'b0;
        #1;
        check("midrst_cen", CEN, 1);
        check("midrst_busy", BUSY, 0);
        check("midrst_rvld", CPU_RVLD, 0);
        fork
            do_req(1'b0, 1'b0, 9'h005, 8'h00);
            do_req(1'b1, 1'b0, 9'h100, 8'h00);
            begin
                repeat (2) @(posedge CLK);
                #3 RST_N = 1'b1;
            end
        join
        repeat (4) @(posedge CLK);

        // both ports requesting continuously: grants must alternate
        fork
            for (int i = 0; i < 4; i++) do_req(1'b0, 1'b0, pick_addr(), 8'($urandom));
            for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, pick_addr(), 8'($urandom));
        join
        repeat (4) @(posedge CLK);

        // randomized traffic with mode changes at arbitrary points
        fork
            begin
                fork
                    rand_port(1'b0, 40);
                    rand_port(1'b1, 40);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    repeat ($urandom_range(3, 15)) @(posedge CLK);
                    #1 LOAD_N = rand_done ? 1'b1 : ~LOAD_N;
                end
                LOAD_N = 1'b1;
            end
        join
        repeat (6) @(posedge CLK);
        #2;
        check("drain_ld", exp_ld.size() + rd_ld.size(), 0);
        check("drain_cpu", exp_cpu.size() + rd_cpu.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scpu_sram_arb.md
SCPU_SRAM_ARB -- requirements
Module: SCPU_SRAM_ARB

Interface
REQ-001 Parameters SHALL be: MEMORY_ADDR_WIDTH, default 9, SRAM address width; MEMORY_DATA_WIDTH, default 8, SRAM data width; PROT_LIM, default 9'h100, CPU write-protect limit.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 LOAD_N  input  1  0 = load mode, loader port only; 1 = run mode, both ports eligible.
REQ-005 LD_REQ, LD_WE  input  1 each  loader request and write enable (1 = write).
REQ-006 LD_A  input  9  loader address; LD_D  input  8  loader write data.
REQ-007 LD_GNT, LD_RVLD  output  1 each  loader grant pulse and read-data-valid pulse; LD_Q  output  8  loader read data.
REQ-008 CPU_REQ, CPU_WE  input  1 each; CPU_A  input  9; CPU_D  input  8  CPU request port, same meaning as the loader port.
REQ-009 CPU_GNT, CPU_RVLD, CPU_ERR  output  1 each; CPU_Q  output  8  CPU grant, read valid, protect-violation pulse and read data.
REQ-010 CEN, WEN  output  1 each  SRAM chip and write enable, active low, registered.
REQ-011 A  output  9; D  output  8  registered SRAM address and write data.
REQ-012 Q  input  8  SRAM read data, valid after the SRAM-sampling edge.
REQ-013 BUSY  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACC and RDCAP.
- IDLE: sample requests; if any eligible request exists, go to ACC; otherwise stay in IDLE.
- ACC: go to RDCAP on a read; go to IDLE on a write or a rejected write.
- RDCAP: always go to IDLE.
REQ-015 Eligibility SHALL be as follows: with LOAD_N=0, only LD_REQ is eligible and CPU_REQ is ignored; with LOAD_N=1, both ports are eligible.
REQ-016 Arbitration with both ports eligible SHALL be round-robin: a one-bit pointer favours one port, and after every grant it moves to favour the other port.
REQ-017 On the edge leaving IDLE, the block SHALL register the winner's A, D and WEN (WEN = ~WE) and drive CEN=0; these values are held for exactly the ACC cycle.
REQ-018 The winner's GNT SHALL be high for exactly the ACC cycle.
REQ-019 On every edge leaving ACC, CEN and WEN SHALL return to 1; A and D hold their last values.
REQ-020 Read latency: the SRAM samples at the end of ACC; the block captures Q into the winner's xx_Q at the end of RDCAP.
REQ-021 xx_RVLD SHALL be high for one cycle, the cycle after RDCAP, and xx_Q holds its value until the next read for that port.
REQ-022 Throughput SHALL be one write per 2 cycles or one read per 3 cycles; there is no back-to-back grant without passing through IDLE.
REQ-023 Handshake: the requester holds REQ, WE, A and D stable until it sees GNT=1, and deasserts REQ on the edge ending the GNT cycle. A REQ still high when IDLE next samples is a new request.
REQ-024 Write protection: a CPU write with CPU_A < PROT_LIM SHALL still be granted (CPU_GNT pulse), but CEN and WEN stay 1 during ACC and CPU_ERR is high for that same ACC cycle.
REQ-025 Write protection SHALL NOT apply to CPU reads or to any loader access.
REQ-026 When LOAD_N changes while the FSM is not IDLE, the access in flight SHALL complete; the new mode takes effect at the next IDLE sample.
REQ-027 A request arriving while the FSM is busy SHALL wait; there is no queueing beyond the requester holding REQ.
REQ-028 When both ports request on the same IDLE edge, exactly one grant SHALL be issued; GNT to both ports in the same cycle is forbidden.

Reset
REQ-029 While RST_N=0 the block SHALL drive: FSM=IDLE, pointer favours loader, CEN=1, WEN=1, A=0, D=0, all GNT/RVLD/ERR=0, LD_Q=0, CPU_Q=0, BUSY=0.
REQ-030 Reset asserted mid-access SHALL abort the access immediately (CEN=1 asynchronously); no RVLD pulse follows for it, and after reset release the first IDLE edge re-arbitrates from the reset pointer.

Verification
REQ-031 Load-mode write: LOAD_N=0, LD write A=9'h005 D=8'hA5 -> one LD_GNT cycle with CEN=0, WEN=0, A=005, D=A5, then IDLE; concurrent CPU_REQ is never granted.
REQ-032 Read latency: preload 9'h105=8'h3C, run-mode CPU read 9'h105 -> CPU_GNT at cycle 1, CPU_RVLD with CPU_Q=8'h3C at cycle 3, BUSY high during cycles 1-2.
REQ-033 Round-robin: LOAD_N=1 with both ports holding read requests continuously -> grants alternate LD, CPU, LD, CPU, with the first grant to LD after reset.
REQ-034 Protect: CPU write A=9'h0FF D=8'h11 -> CPU_GNT=1 and CPU_ERR=1 in the same cycle, CEN stays 1, and a loader readback of 0FF returns the old value; CPU write to 9'h100 succeeds.
REQ-035 Reset mid-read: RST_N pulled low during RDCAP -> CEN=1 and BUSY=0 immediately, no CPU_RVLD; after release a pending LD_REQ is granted first.
